// File: rtl/maxterm_sweep_ctrl.sv
// Sweep sequencer for 3-input maxterm function units: steps {x,y,z} through
// 0..7, samples every unit's resp after a settle delay and checks it against a latched truth table.
module maxterm_sweep_ctrl #(
    parameter int NFUNC  = 5,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [8*NFUNC-1:0] exp_mask,
    input  logic [NFUNC-1:0]   dut_resp,
    output logic               x,
    output logic               y,
    output logic               z,
    output logic [2:0]         cont,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NFUNC-1:0]   fail_vec,
    output logic [2:0]         first_fail_idx,
    output logic               first_fail_vld
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    logic [1:0]         state;
    logic [CW-1:0]      settle_cnt;
    logic [8*NFUNC-1:0] mask;
    logic [NFUNC-1:0]   mism;
    logic [NFUNC-1:0]   fail_next;

    // cont is the registered index; the stimulus pins are just its bits
    assign {x, y, z} = cont;

    for (genvar f = 0; f < NFUNC; f++) begin : g_mism
        logic [7:0] tab;
        assign tab     = mask[8*f +: 8];
        assign mism[f] = dut_resp[f] ^ tab[cont];
    end

    assign fail_next = fail_vec | mism;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cont           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_vec       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            settle_cnt     <= '0;
            mask           <= '0;
        end else begin
            done <= 1'b0;
            // abort overrides every transition; partial fail_vec is preserved
            if (abort) begin
                state      <= IDLE;
                cont       <= '0;
                busy       <= 1'b0;
                settle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cont <= '0;
                        if (start) begin
                            mask           <= exp_mask;
                            fail_vec       <= '0;
                            pass           <= 1'b0;
                            first_fail_vld <= 1'b0;
                            settle_cnt     <= '0;
                            busy           <= 1'b1;
                            state          <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt + CW'(1);
                        end
                    end
                    SAMPLE: begin
                        fail_vec   <= fail_next;
                        settle_cnt <= '0;
                        if ((mism != '0) && !first_fail_vld) begin
                            first_fail_idx <= cont;
                            first_fail_vld <= 1'b1;
                        end
                        if (cont == 3'd7) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_next == '0);
                            cont  <= '0;
                        end else begin
                            cont  <= cont + 3'd1;
                            state <= DRIVE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maxterm_sweep_ctrl.sv
// Directed bench for maxterm_sweep_ctrl: behavioural maxterm units drive dut_resp,
// expected sweep results are queued at start and checked when done pulses.
module tb_maxterm_sweep_ctrl;

    localparam int NF = 5;
    localparam logic [39:0] GOLD = 40'h99_5C_C5_75_3B;
    localparam logic [39:0] BAD  = 40'h99_5C_C5_75_3F;

    typedef struct packed {
        logic [4:0] fv;
        logic [2:0] ffi;
        logic       ffv;
        logic       pass;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [39:0] exp_mask = '0;
    logic [4:0]  dut_resp;
    logic        x, y, z;
    logic [2:0]  cont;
    logic        busy, done, pass;
    logic [4:0]  fail_vec;
    logic [2:0]  first_fail_idx;
    logic        first_fail_vld;

    int n_checks = 0;
    int n_err    = 0;
    res_t sb[$];

    maxterm_sweep_ctrl #(.NFUNC(NF), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .exp_mask(exp_mask), .dut_resp(dut_resp),
        .x(x), .y(y), .z(z), .cont(cont), .busy(busy), .done(done), .pass(pass),
        .fail_vec(fail_vec), .first_fail_idx(first_fail_idx),
        .first_fail_vld(first_fail_vld)
    );

    always #5 clk = ~clk;

    // Units A..E: resp is 0 exactly at the listed maxterm indices
    function automatic logic [4:0] units(input logic [2:0] i);
        logic [4:0] r;
        r[0] = !(i == 3'd2 || i == 3'd6 || i == 3'd7);
        r[1] = !(i == 3'd1 || i == 3'd3 || i == 3'd7);
        r[2] = !(i == 3'd1 || i == 3'd3 || i == 3'd4 || i == 3'd5);
        r[3] = !(i == 3'd0 || i == 3'd1 || i == 3'd5 || i == 3'd7);
        r[4] = !(i == 3'd1 || i == 3'd2 || i == 3'd5 || i == 3'd6);
        return r;
    endfunction

    function automatic res_t model(input logic [39:0] m);
        res_t       r;
        logic [2:0] ii;
        logic [2:0] fi;
        logic [4:0] u;
        logic [4:0] mm;
        logic [7:0] b;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            ii = 3'(i);
            u  = units(ii);
            mm = '0;
            for (int f = 0; f < NF; f++) begin
                fi     = 3'(f);
                b      = 8'(m >> (8 * f));
                mm[fi] = u[fi] ^ b[ii];
            end
            if (mm != '0 && !r.ffv) begin
                r.ffi = ii;
                r.ffv = 1'b1;
            end
            r.fv = r.fv | mm;
        end
        r.pass = (r.fv == '0);
        return r;
    endfunction

    always_comb dut_resp = units({x, y, z});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic kick(input logic [39:0] m);
        exp_mask = m;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_cont(input logic [2:0] v, input string tag);
        int n;
        n = 0;
        while (cont !== v && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(cont), 32'(v));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    // Scoreboard: pop one expected result for every done pulse
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            res_t e;
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_fail_vec", 32'(fail_vec), 32'(e.fv));
                chk("sb_ff_vld", 32'(first_fail_vld), 32'(e.ffv));
                chk("sb_pass", 32'(pass), 32'(e.pass));
                if (e.ffv) chk("sb_ff_idx", 32'(first_fail_idx), 32'(e.ffi));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         done_seen;
        logic [63:0] r64;
        logic [39:0] rm;

        // T1: reset held with start asserted
        rst_n    = 1'b0;
        start    = 1'b1;
        exp_mask = GOLD;
        repeat (3) step();
        chk("rst_outs", 32'({x, y, z, cont, busy, done, pass, fail_vec,
                             first_fail_idx, first_fail_vld}), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cont", 32'(cont), 32'd0);

        // T2: golden sweep, index stepping and done latency
        sb.push_back('{fv: 5'd0, ffi: 3'd0, ffv: 1'b0, pass: 1'b1});
        kick(GOLD);
        for (int i = 0; i < 8; i++) begin
            chk("t2_xyz", 32'({x, y, z}), 32'(i));
            chk("t2_busy", 32'(busy), 32'd1);
            step();
            chk("t2_xyz_hold", 32'({x, y, z}), 32'(i));
            chk("t2_done_early", 32'(done), 32'd0);
            step();
        end
        chk("t2_done_edge16", 32'(done), 32'd1);
        chk("t2_busy_done", 32'(busy), 32'd0);
        step();
        chk("t2_done_pulse", 32'(done), 32'd0);
        chk("t2_pass_hold", 32'(pass), 32'd1);

        // T3: wrong truth table for unit A at index 2
        sb.push_back('{fv: 5'b00001, ffi: 3'd2, ffv: 1'b1, pass: 1'b0});
        kick(BAD);
        wait_done(cyc);
        chk("t3_latency", 32'(cyc), 32'd16);
        step();

        // Last-index mismatch (unit E, index 7) must still fail the sweep
        sb.push_back('{fv: 5'b10000, ffi: 3'd7, ffv: 1'b1, pass: 1'b0});
        kick(GOLD ^ 40'h80_00_00_00_00);
        wait_done(cyc);
        chk("last_latency", 32'(cyc), 32'd16);
        step();

        // Random truth tables checked against the behavioural model
        for (int k = 0; k < 2; k++) begin
            r64 = {$urandom(), $urandom()};
            rm  = r64[39:0];
            sb.push_back(model(rm));
            kick(rm);
            wait_done(cyc);
            chk("rand_latency", 32'(cyc), 32'd16);
            step();
        end

        // T4: abort at index 4 keeps the partial fail_vec and never completes
        kick(BAD);
        wait_cont(3'd4, "t4_reach4");
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_xyz", 32'({x, y, z}), 32'd0);
        chk("t4_partial", 32'(fail_vec), 32'b00001);
        done_seen = 0;
        repeat (20) begin
            step();
            if (done === 1'b1) done_seen = 1;
        end
        chk("t4_no_done", 32'(done_seen), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("t4_abort_wins", 32'(busy), 32'd0);
        step();
        chk("t4_still_idle", 32'(busy), 32'd0);

        // T5: mid-sweep start and mask change ignored; start held through DONE
        sb.push_back('{fv: 5'b00001, ffi: 3'd2, ffv: 1'b1, pass: 1'b0});
        kick(BAD);
        exp_mask = GOLD;
        wait_cont(3'd3, "t5_reach3");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_cont_after_pulse", 32'(cont), 32'd3);
        wait_cont(3'd7, "t5_reach7");
        sb.push_back('{fv: 5'd0, ffi: 3'd0, ffv: 1'b0, pass: 1'b1});
        start = 1'b1;
        wait_done(cyc);
        step();
        chk("t5_done_ignores_start", 32'(busy), 32'd0);
        step();
        chk("t5_restart_busy", 32'(busy), 32'd1);
        chk("t5_restart_cleared", 32'(fail_vec), 32'd0);
        start = 1'b0;
        wait_done(cyc);
        chk("t5_restart_latency", 32'(cyc), 32'd16);
        step();

        // T6: asynchronous reset mid-sweep, between clock edges
        kick(GOLD);
        wait_cont(3'd5, "t6_reach5");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", 32'({x, y, z, cont, busy, done, pass, fail_vec,
                             first_fail_idx, first_fail_vld}), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
